pll_freq_meter: RTL

Single-clock frequency meter that checks PLL outputs against expected frequencies. The 50 MHz board clock drives the block. A PLL output clock enters as a plain data signal on `meas_in`, passes through a synchronizer, and the block counts its rising edges over a fixed gate window. It reports the count, a range check and lock-loss status. It sits next to the PLL instances and consumes their `CLK_OUT*` and `LOCKED` signals; one instance is used per measured clock.

---
 rtl/pll_freq_meter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pll_freq_meter.sv
// pll_freq_meter
// Counts rising edges of a PLL output clock over a fixed gate window of
// clk cycles and reports the count, a range check and a lock-loss flag.
// meas_in and locked are asynchronous and are synchronized here; one instance
// is needed per measured clock.
//
// Ports
//   clk        system clock (only clock of the block)
//   rst_n      synchronous active-low reset
//   meas_in    clock under test, treated as asynchronous data, < clk/4
//   locked     PLL LOCKED, asynchronous
//   start      single-cycle measurement request, ignored while busy
//   busy       high from start acceptance until done
//   done       one-cycle pulse when results are valid
//   edge_count rising edges counted in the last window
//   in_range   EXP_MIN <= edge_count <= EXP_MAX, no saturation, no lock loss
//   overflow   edge counter saturated during the last window
//   lock_lost  last measurement aborted because locked fell
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start; results held
// S_WAIT_LOCK | start accepted, waiting for synchronized locked (no timeout)
// S_MEASURE   | gate window running, counting synchronized rising edges
// S_REPORT    | one cycle: latch results, pulse done

module pll_freq_meter #(
   parameter int GATE_CYCLES = 50000,
   parameter int CNT_W       = 16,
   parameter int EXP_MIN     = 4990,
   parameter int EXP_MAX     = 5010
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             meas_in,
   input  logic             locked,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] edge_count,
   output logic             in_range,
   output logic             overflow,
   output logic             lock_lost
);

   localparam int                GATE_W     = $clog2(GATE_CYCLES + 1);
   localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
   localparam logic [GATE_W-1:0] GATE_ONE   = GATE_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_MAX_M1 = CNT_MAX - CNT_ONE;
   localparam logic [CNT_W-1:0]  EXP_MIN_C  = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0]  EXP_MAX_C  = CNT_W'(EXP_MAX);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_LOCK = 2'd1,
      S_MEASURE   = 2'd2,
      S_REPORT    = 2'd3
   } state_t;

   state_t            state;
   logic              m1, m2, m3;
   logic              lk1, lk;
   logic              rise;
   logic [GATE_W-1:0] gate_cnt;
   logic [CNT_W-1:0]  edge_cnt;
   logic              overflow_int;
   logic              lock_lost_int;

   // m1 is the metastability catcher; the edge is taken between m2 and m3
   // so that only settled samples feed the counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m1  <= 1'b0;
         m2  <= 1'b0;
         m3  <= 1'b0;
         lk1 <= 1'b0;
         lk  <= 1'b0;
      end else begin
         m1  <= meas_in;
         m2  <= m1;
         m3  <= m2;
         lk1 <= locked;
         lk  <= lk1;
      end
   end

   assign rise = m2 & ~m3;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         gate_cnt      <= '0;
         edge_cnt      <= '0;
         overflow_int  <= 1'b0;
         lock_lost_int <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         edge_count    <= '0;
         in_range      <= 1'b0;
         overflow      <= 1'b0;
         lock_lost     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  gate_cnt      <= '0;
                  edge_cnt      <= '0;
                  overflow_int  <= 1'b0;
                  lock_lost_int <= 1'b0;
                  busy          <= 1'b1;
                  state         <= lk ? S_MEASURE : S_WAIT_LOCK;
               end
            end

            S_WAIT_LOCK: begin
               if (lk) state <= S_MEASURE;
            end

            S_MEASURE: begin
               gate_cnt <= gate_cnt + GATE_ONE;
               // Counter sticks at all-ones; reaching it flags overflow since
               // any further edge would be lost.
               if (rise && (edge_cnt != CNT_MAX)) begin
                  edge_cnt <= edge_cnt + CNT_ONE;
                  if (edge_cnt == CNT_MAX_M1) overflow_int <= 1'b1;
               end
               // Lock loss wins over gate expiry; the partial count is kept.
               if (!lk) begin
                  lock_lost_int <= 1'b1;
                  state         <= S_REPORT;
               end else if (gate_cnt == GATE_LAST) begin
                  state <= S_REPORT;
               end
            end

            S_REPORT: begin
               edge_count <= edge_cnt;
               overflow   <= overflow_int;
               lock_lost  <= lock_lost_int;
               in_range   <= (edge_cnt >= EXP_MIN_C) && (edge_cnt <= EXP_MAX_C) &&
                             !overflow_int && !lock_lost_int;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
